// File: rtl/dilithium_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dilithium_pkg
// Description : Shared constants, controller state encoding and K lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package dilithium_pkg;

    localparam int N            = 256;
    localparam int K_MAX        = 8;
    localparam int COEFF_W_DEF  = 24;
    localparam int OUTPUT_W_DEF = 4;
    localparam int ADDR_W_DEF   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // Polynomial count for a security level; 0 marks an unsupported level.
    function automatic logic [3:0] k_of_sec(input logic [2:0] sec_lvl);
        case (sec_lvl)
            3'd2:    k_of_sec = 4'd4;
            3'd3:    k_of_sec = 4'd6;
            3'd5:    k_of_sec = 4'd8;
            default: k_of_sec = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decompose_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : decompose_ctrl_if
// Description : Control, memory and decomposer bus of decompose_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface decompose_ctrl_if import dilithium_pkg::*; #(
    parameter int OUTPUT_W = OUTPUT_W_DEF,
    parameter int COEFF_W  = COEFF_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) ();

    localparam int DATA_W = OUTPUT_W * COEFF_W;

    logic              start;
    logic [2:0]        sec_lvl;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              dec_valid_i;
    logic              dec_ready_i;
    logic [DATA_W-1:0] dec_di;
    logic [DATA_W-1:0] dec_doa;
    logic [DATA_W-1:0] dec_dob;
    logic              dec_valid_o;
    logic              dec_ready_o;
    logic              wr_stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_doa;
    logic [DATA_W-1:0] wr_dob;

    modport master (
        input  start, sec_lvl, rd_base, wr_base, rd_data, dec_ready_i,
               dec_doa, dec_dob, dec_valid_o, wr_stall,
        output busy, done, err, rd_en, rd_addr, dec_valid_i, dec_di,
               dec_ready_o, wr_en, wr_addr, wr_doa, wr_dob
    );

    modport slave (
        output start, sec_lvl, rd_base, wr_base, rd_data, dec_ready_i,
               dec_doa, dec_dob, dec_valid_o, wr_stall,
        input  busy, done, err, rd_en, rd_addr, dec_valid_i, dec_di,
               dec_ready_o, wr_en, wr_addr, wr_doa, wr_dob
    );

endinterface
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : skid_fifo2
// Description : Two-entry valid/ready FIFO with occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    assign pop_valid = (r_occ != 2'd0);
    assign pop_data  = r_mem0;
    assign occupancy = r_occ;
    assign w_pop     = pop_valid & pop_ready;
    // Producer is expected to respect occupancy; a push into a full FIFO is dropped.
    assign w_push    = push_valid & ((r_occ != 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_mem0 <= push_data;
                    else               r_mem1 <= push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_mem0 <= push_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/decompose_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decompose_ctrl
// Description : Streams the w vector through one decomposer and writes w1/w0.
// Revision    : 1.0 - initial release
// ============================================================================
module decompose_ctrl import dilithium_pkg::*; #(
    parameter int OUTPUT_W = OUTPUT_W_DEF,
    parameter int COEFF_W  = COEFF_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    decompose_ctrl_if.master  bus
);

    localparam int DATA_W         = OUTPUT_W * COEFF_W;
    localparam int WORDS_PER_POLY = N / OUTPUT_W;
    localparam int CNT_W          = $clog2(K_MAX * WORDS_PER_POLY + 1);

    ctrl_state_t       r_state;
    logic [3:0]        r_k;
    logic [ADDR_W-1:0] r_rd_base;
    logic [ADDR_W-1:0] r_wr_base;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_in_flight;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [CNT_W-1:0]  w_total;
    logic [3:0]        w_start_k;
    logic              w_active;
    logic              w_dec_ready_o;
    logic              w_head_valid;
    logic [DATA_W-1:0] w_head_data;
    logic [1:0]        w_occ;
    logic              w_pop;
    logic [2:0]        w_credit_used;
    logic              w_rd_en;
    logic              w_wr_en;

    assign w_total   = CNT_W'(r_k) * CNT_W'(WORDS_PER_POLY);
    assign w_start_k = k_of_sec(bus.sec_lvl);
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    // Credit counts a word leaving the buffer this cycle so a steady stream
    // sustains one read per cycle without ever overfilling the two entries.
    assign w_pop         = w_head_valid & bus.dec_ready_i;
    assign w_credit_used = {1'b0, w_occ} + {2'b00, r_in_flight} - {2'b00, w_pop};
    assign w_rd_en       = (r_state == ST_RUN) && (w_credit_used < 3'd2);

    assign w_dec_ready_o = w_active & ~bus.wr_stall;
    assign w_wr_en       = bus.dec_valid_o & w_dec_ready_o;

    skid_fifo2 #(
        .WIDTH (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (r_in_flight),
        .push_data  (bus.rd_data),
        .pop_valid  (w_head_valid),
        .pop_ready  (bus.dec_ready_i),
        .pop_data   (w_head_data),
        .occupancy  (w_occ)
    );

    assign bus.rd_en       = w_rd_en;
    assign bus.rd_addr     = r_rd_base + ADDR_W'(r_rd_cnt);
    assign bus.dec_valid_i = w_head_valid;
    assign bus.dec_di      = w_head_data;
    assign bus.dec_ready_o = w_dec_ready_o;
    assign bus.wr_en       = w_wr_en;
    assign bus.wr_addr     = r_wr_base + ADDR_W'(r_wr_cnt);
    assign bus.wr_doa      = bus.dec_doa;
    assign bus.wr_dob      = bus.dec_dob;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= 4'd0;
            r_rd_base   <= '0;
            r_wr_base   <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_in_flight <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_in_flight <= w_rd_en;
            if (w_rd_en) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            if (w_wr_en) r_wr_cnt <= r_wr_cnt + CNT_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_start_k == 4'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN;
                            r_busy    <= 1'b1;
                            r_k       <= w_start_k;
                            r_rd_base <= bus.rd_base;
                            r_wr_base <= bus.wr_base;
                            r_rd_cnt  <= '0;
                            r_wr_cnt  <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_rd_en && (r_rd_cnt == w_total - CNT_W'(1))) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_wr_en && (r_wr_cnt == w_total - CNT_W'(1))) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decompose_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decompose_ctrl
// Description : Self-checking bench with memory/decomposer models and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decompose_ctrl;
    import dilithium_pkg::*;

    localparam int OW = OUTPUT_W_DEF;
    localparam int CW = COEFF_W_DEF;
    localparam int AW = ADDR_W_DEF;
    localparam int DW = OW * CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decompose_ctrl_if #(.OUTPUT_W(OW), .COEFF_W(CW), .ADDR_W(AW)) bus ();

    decompose_ctrl #(.OUTPUT_W(OW), .COEFF_W(CW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference memory contents and the decomposer's per-coefficient split
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        logic [31:0]   h;
        for (int i = 0; i < OW; i++) begin
            h = ((32'(a) + 32'd1) * 32'd2654435761) ^ (32'(i) * 32'h9E3779B9);
            w[i*CW +: CW] = CW'(h[31:8]);
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] dec_hi(input logic [DW-1:0] x);
        logic [DW-1:0] w;
        for (int i = 0; i < OW; i++) w[i*CW +: CW] = x[i*CW +: CW] >> 13;
        return w;
    endfunction

    function automatic logic [DW-1:0] dec_lo(input logic [DW-1:0] x);
        logic [DW-1:0] w;
        for (int i = 0; i < OW; i++) w[i*CW +: CW] = x[i*CW +: CW] & CW'(24'h1FFF);
        return w;
    endfunction

    // Single-port memory: data one cycle after rd_en
    always @(posedge clk) begin
        if (rst)            bus.rd_data <= '0;
        else if (bus.rd_en) bus.rd_data <= mem_word(bus.rd_addr);
    end

    // One-stage decomposer model with an external ready hold
    logic          tb_hold;
    logic          m_v;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    assign bus.dec_ready_i = ~tb_hold & (~m_v | bus.dec_ready_o);
    assign bus.dec_valid_o = m_v;
    assign bus.dec_doa     = m_a;
    assign bus.dec_dob     = m_b;

    always @(posedge clk) begin
        if (rst) begin
            m_v <= 1'b0;
            m_a <= '0;
            m_b <= '0;
        end else begin
            if (m_v && bus.dec_ready_o) m_v <= 1'b0;
            if (bus.dec_valid_i && bus.dec_ready_i) begin
                m_v <= 1'b1;
                m_a <= dec_hi(bus.dec_di);
                m_b <= dec_lo(bus.dec_di);
            end
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    typedef struct {
        logic [2:0]    sec;
        logic [AW-1:0] rb;
        logic [AW-1:0] wb;
        int            stall;
        int            n;
        logic [AW-1:0] last;
        logic          err;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[6];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            stall_pct = 0;
    int            hold_left = 0;
    int            start_cyc, first_rd_cyc, last_wr_cyc, done_cyc, err_cyc;
    int            rd_cnt, wr_cnt, done_cnt, err_cnt, busy_cnt, max_occ, hold_rd, late_rd;
    logic [AW-1:0] exp_rd_base, exp_wr_base, last_wr_addr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        sb.delete();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        max_occ = 0; hold_rd = 0; late_rd = 0; last_wr_addr = '0;
        first_rd_cyc = -1; last_wr_cyc = -1; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic sample();
        logic [AW-1:0] ra;
        logic [DW-1:0] w;
        exp_t          e;
        if (bus.busy) busy_cnt++;
        if (int'(dut.u_skid.occupancy) > max_occ) max_occ = int'(dut.u_skid.occupancy);
        if (bus.rd_en) begin
            ra = exp_rd_base + AW'(rd_cnt);
            check("rd_addr", 128'(bus.rd_addr), 128'(ra));
            if (rd_cnt == 0) first_rd_cyc = cyc;
            w      = mem_word(ra);
            e.addr = exp_wr_base + AW'(rd_cnt);
            e.a    = dec_hi(w);
            e.b    = dec_lo(w);
            sb.push_back(e);
            if (tb_hold) begin
                hold_rd++;
                if (hold_left <= 10) late_rd++;
            end
            rd_cnt++;
        end
        if (bus.wr_en) begin
            check("sb_nonempty_at_wr", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 128'(bus.wr_addr), 128'(e.addr));
                check("wr_doa", 128'(bus.wr_doa), 128'(e.a));
                check("wr_dob", 128'(bus.wr_dob), 128'(e.b));
            end
            last_wr_cyc  = cyc;
            last_wr_addr = bus.wr_addr;
            wr_cnt++;
        end
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.err)  begin err_cnt++;  err_cyc  = cyc; end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) sample();
        @(posedge clk);
        #1;
        cyc++;
        bus.wr_stall = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
        if (hold_left > 0) hold_left--;
        tb_hold = (hold_left > 0);
    endtask

    task automatic check_zero();
        @(negedge clk);
        check("z_busy",  128'(bus.busy), 128'(0));
        check("z_done",  128'(bus.done), 128'(0));
        check("z_err",   128'(bus.err), 128'(0));
        check("z_rd_en", 128'(bus.rd_en), 128'(0));
        check("z_rd_addr", 128'(bus.rd_addr), 128'(0));
        check("z_dec_valid_i", 128'(bus.dec_valid_i), 128'(0));
        check("z_dec_di", 128'(bus.dec_di), 128'(0));
        check("z_dec_ready_o", 128'(bus.dec_ready_o), 128'(0));
        check("z_wr_en", 128'(bus.wr_en), 128'(0));
        check("z_wr_addr", 128'(bus.wr_addr), 128'(0));
        check("z_wr_doa", 128'(bus.wr_doa), 128'(0));
        check("z_wr_dob", 128'(bus.wr_dob), 128'(0));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_pass(input logic [2:0] sec, input logic [AW-1:0] rb, input logic [AW-1:0] wb);
        clear_counts();
        exp_rd_base = rb;
        exp_wr_base = wb;
        bus.sec_lvl = sec;
        bus.rd_base = rb;
        bus.wr_base = wb;
        bus.start   = 1'b1;
        start_cyc   = cyc;
        tick();
        bus.start   = 1'b0;
        bus.rd_base = ~rb;
        bus.wr_base = ~wb;
    endtask

    task automatic finish_pass(input int n, input logic [AW-1:0] last);
        int b;
        b = 0;
        while (done_cnt == 0 && b < 4000) begin
            tick();
            b++;
        end
        check("done_within_budget", 128'(done_cnt != 0), 128'(1));
        repeat (3) tick();
        check("rd_count", 128'(rd_cnt), 128'(n));
        check("wr_count", 128'(wr_cnt), 128'(n));
        check("done_count", 128'(done_cnt), 128'(1));
        check("err_count", 128'(err_cnt), 128'(0));
        check("last_wr_addr", 128'(last_wr_addr), 128'(last));
        check("first_rd_latency", 128'(first_rd_cyc), 128'(start_cyc + 1));
        check("done_after_last_wr", 128'(done_cyc), 128'(last_wr_cyc + 1));
        check("sb_drained", 128'(sb.size()), 128'(0));
        check("occ_le_2", 128'(max_occ <= 2), 128'(1));
        check("busy_after_done", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd2, 10'h000, 10'h100, 0,  256, 10'h1FF, 1'b0};
        vecs[1] = '{3'd5, 10'h050, 10'h380, 30, 512, 10'h17F, 1'b0};
        vecs[2] = '{3'd3, 10'h3F0, 10'h000, 0,  384, 10'h17F, 1'b0};
        vecs[3] = '{3'd4, 10'h000, 10'h000, 0,  0,   10'h000, 1'b1};
        vecs[4] = '{3'd0, 10'h000, 10'h000, 0,  0,   10'h000, 1'b1};
        vecs[5] = '{3'd7, 10'h000, 10'h000, 0,  0,   10'h000, 1'b1};

        bus.start    = 1'b0;
        bus.sec_lvl  = 3'd0;
        bus.rd_base  = '0;
        bus.wr_base  = '0;
        bus.wr_stall = 1'b0;
        tb_hold      = 1'b0;
        clear_counts();
        exp_rd_base  = '0;
        exp_wr_base  = '0;
        start_cyc    = 0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_zero();

        for (int v = 0; v < 6; v++) begin
            stall_pct = vecs[v].stall;
            start_pass(vecs[v].sec, vecs[v].rb, vecs[v].wb);
            if (vecs[v].err) begin
                repeat (5) tick();
                check("err_count", 128'(err_cnt), 128'(1));
                check("err_latency", 128'(err_cyc), 128'(start_cyc + 1));
                check("err_busy", 128'(busy_cnt), 128'(0));
                check("err_rd", 128'(rd_cnt), 128'(0));
                check("err_wr", 128'(wr_cnt), 128'(0));
                check("err_done", 128'(done_cnt), 128'(0));
            end else begin
                finish_pass(vecs[v].n, vecs[v].last);
            end
            stall_pct = 0;
            repeat (2) tick();
        end

        // Decomposer stops accepting for 20 cycles mid-pass
        start_pass(3'd3, 10'h040, 10'h140);
        repeat (30) tick();
        hold_left = 20;
        tb_hold   = 1'b1;
        repeat (25) tick();
        check("hold_reads_le_2", 128'(hold_rd <= 2), 128'(1));
        check("hold_late_reads", 128'(late_rd), 128'(0));
        finish_pass(384, 10'h2BF);
        repeat (2) tick();

        // Second start while busy must be ignored
        start_pass(3'd3, 10'h200, 10'h000);
        repeat (49) tick();
        bus.sec_lvl = 3'd2;
        bus.rd_base = 10'h000;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        finish_pass(384, 10'h17F);
        repeat (2) tick();

        // Reset in the middle of a pass, then a fresh pass
        start_pass(3'd3, 10'h123, 10'h222);
        repeat (39) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_counts();
        check_zero();
        repeat (10) tick();
        check("abort_no_done", 128'(done_cnt), 128'(0));
        check("abort_no_rd", 128'(rd_cnt), 128'(0));
        check("abort_no_wr", 128'(wr_cnt), 128'(0));
        start_pass(3'd3, 10'h010, 10'h020);
        finish_pass(384, 10'h19F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
